uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits
//
// Ports:
//   clk       - single clock, all state changes on the rising edge
//   rst_n     - asynchronous active-low reset
//   tx_valid  - a frame request is presented on tx_data
//   tx_data   - payload, DATA_BITS wide, captured when tx_valid && tx_ready
//   tx_ready  - high only while idle; one request is accepted per frame
//   TX_data   - serial line, idle high, driven from a register
//   sel       - current field: 00 START, 01 DATA, 10 PARITY, 11 STOP/idle
//   tx_done   - one-cycle pulse on the last cycle of the last stop bit
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TX_data,
    output logic [1:0]           sel,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  DATA_LAST   = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST   = (STOP_BITS == 2);
    localparam logic        HAS_PARITY  = (PARITY_EN != 0);
    localparam logic        ODD_PARITY  = (PARITY_ODD != 0);

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            bit_cnt;
    logic [15:0]            bit_cnt_next;
    logic [2:0]             data_idx;
    logic [2:0]             data_idx_next;
    logic                   stop_idx;
    logic                   stop_idx_next;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_next;
    logic                   parity_bit;
    logic                   parity_next;
    logic                   line_q;
    logic                   line_next;
    logic                   ready_q;
    logic                   ready_next;
    logic                   bit_last;

    assign bit_last = (bit_cnt == BIT_LAST);

    // State register. ready_q resets low so tx_ready only rises on the
    // first clock edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_idx   <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            line_q     <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            data_idx   <= data_idx_next;
            stop_idx   <= stop_idx_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            line_q     <= line_next;
            ready_q    <= ready_next;
        end
    end

    // Next-state logic. The line value is computed for the state being
    // entered so the serial output changes in the same edge as the state,
    // straight out of a flop.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_last ? 16'd0 : bit_cnt + 16'd1;
        data_idx_next = data_idx;
        stop_idx_next = stop_idx;
        shreg_next    = shreg;
        parity_next   = parity_bit;
        line_next     = line_q;

        case (state)
            IDLE: begin
                bit_cnt_next = 16'd0;
                line_next    = 1'b1;
                if (tx_valid && ready_q) begin
                    state_next  = START;
                    shreg_next  = tx_data;
                    parity_next = (^tx_data) ^ ODD_PARITY;
                    line_next   = 1'b0;
                end
            end
            START: begin
                if (bit_last) begin
                    state_next    = DATA;
                    data_idx_next = 3'd0;
                    line_next     = shreg[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    // Shift register: bit 0 is always the bit on the line.
                    shreg_next = shreg >> 1;
                    if (data_idx == DATA_LAST) begin
                        if (HAS_PARITY) begin
                            state_next = PARITY;
                            line_next  = parity_bit;
                        end else begin
                            state_next    = STOP;
                            stop_idx_next = 1'b0;
                            line_next     = 1'b1;
                        end
                    end else begin
                        data_idx_next = data_idx + 3'd1;
                        line_next     = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_last) begin
                    state_next    = STOP;
                    stop_idx_next = 1'b0;
                    line_next     = 1'b1;
                end
            end
            STOP: begin
                line_next = 1'b1;
                if (bit_last) begin
                    if (stop_idx == STOP_LAST) begin
                        state_next = IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                line_next  = 1'b1;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    always_comb begin
        sel = 2'b11;
        case (state)
            START:   sel = 2'b00;
            DATA:    sel = 2'b01;
            PARITY:  sel = 2'b10;
            default: sel = 2'b11;
        endcase
    end

    assign tx_done  = (state == STOP) && bit_last && (stop_idx == STOP_LAST);
    assign tx_ready = ready_q;
    assign TX_data  = line_q;

endmodule
